// File: rtl/fpu_decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// fpu_decode_stage_pkg
// Shared types and constants for the half-precision (Zhinx) FPU issue stage:
//   - rv32zhinx_insn_t : raw OP-FP / fused instruction field layout
//   - fpu_operation_t  : 4-bit operation code handed to the execute datapath
//   - fpu_sgnj_rm_t    : sub-op select carried in rm for FSGNJ*
//   - fpu_decoded_t    : decoded record stored in the issue FIFO
// Optional feature macro used by the importing modules: FPU_FUSED_EN.
// -----------------------------------------------------------------------------
package fpu_decode_stage_pkg;

    localparam int DATA_W = 16;

    // Major opcodes
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [1:0] FMT_HALF = 2'b10;

    // OP-FP funct5 values
    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_COMP   = 5'b10100;
    localparam logic [4:0] F5_CLASS  = 5'b11100;

    // Rounding-mode encodings
    localparam logic [2:0] RM_RNE         = 3'b000;
    localparam logic [2:0] RM_RTZ         = 3'b001;
    localparam logic [2:0] RM_DYN         = 3'b111;
    localparam logic [2:0] RM_ILLEGAL_101 = 3'b101;
    localparam logic [2:0] RM_ILLEGAL_110 = 3'b110;
    localparam logic [2:0] RM_ILLEGAL_111 = 3'b111;

    typedef enum logic [3:0] {
        FPU_HALF_ADD    = 4'd0,
        FPU_HALF_SUB    = 4'd1,
        FPU_HALF_MUL    = 4'd2,
        FPU_HALF_DIV    = 4'd3,
        FPU_HALF_SQRT   = 4'd4,
        FPU_HALF_MINMAX = 4'd5,
        FPU_HALF_SGNJ   = 4'd6,
        FPU_HALF_COMP   = 4'd7,
        FPU_HALF_CLASS  = 4'd8,
        FPU_HALF_MADD   = 4'd9,
        FPU_HALF_MSUB   = 4'd10,
        FPU_HALF_NMADD  = 4'd11,
        FPU_HALF_NMSUB  = 4'd12
    } fpu_operation_t;

    typedef enum logic [2:0] {
        FPU_SGNJ  = 3'b000,
        FPU_SGNJN = 3'b001,
        FPU_SGNJX = 3'b010
    } fpu_sgnj_rm_t;

    // funct5 doubles as rs3 for the fused (R4) formats
    typedef struct packed {
        logic [4:0] funct5;
        logic [1:0] fmt;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] rm;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv32zhinx_insn_t;

    typedef struct packed {
        fpu_operation_t    op;
        logic [2:0]        rm;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [4:0]        rd;
        logic              illegal;
    } fpu_decoded_t;

endpackage

// File: rtl/fpu_insn_decoder.sv
// -----------------------------------------------------------------------------
// fpu_insn_decoder
// Purely combinational decode of one OP-FP / fused half-precision instruction
// into an fpu_decoded_t record, resolving the dynamic rounding mode from frm.
// Ports:
//   insn       in  32  raw instruction (rv32zhinx_insn_t layout)
//   frm        in   3  current dynamic rounding mode
//   op_a/b/c   in  16  rs1/rs2/rs3 operand halves
//   dec        out     decoded record (op, rm, a, b, c, rd, illegal)
// Macro: FPU_FUSED_EN enables the four fused opcodes; otherwise they decode
// as illegal and dec.c is 0.
// -----------------------------------------------------------------------------
module fpu_insn_decoder
    import fpu_decode_stage_pkg::*;
(
    input  logic [31:0]       insn,
    input  logic [2:0]        frm,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_c,
    output fpu_decoded_t      dec
);

    function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] dyn_rm);
        return (rm == RM_DYN) ? dyn_rm : rm;
    endfunction

    function automatic logic rm_is_illegal(input logic [2:0] rm);
        return (rm == RM_ILLEGAL_101) || (rm == RM_ILLEGAL_110) || (rm == RM_ILLEGAL_111);
    endfunction

    rv32zhinx_insn_t f;
    assign f = rv32zhinx_insn_t'(insn);

    fpu_operation_t op;
    logic           uses_rm;
    logic           illegal;
    logic [2:0]     rm_res;
    logic           is_half;

    assign is_half = (f.fmt == FMT_HALF);

    always_comb begin
        op      = FPU_HALF_ADD;
        uses_rm = 1'b0;
        illegal = 1'b0;
        rm_res  = resolve_rm(f.rm, frm);
        dec     = '0;

        case (f.opcode)
            OPC_OP_FP: begin
                if (!is_half) begin
                    illegal = 1'b1;
                end else begin
                    case (f.funct5)
                        F5_ADD: begin op = FPU_HALF_ADD; uses_rm = 1'b1; end
                        F5_SUB: begin op = FPU_HALF_SUB; uses_rm = 1'b1; end
                        F5_MUL: begin op = FPU_HALF_MUL; uses_rm = 1'b1; end
                        F5_DIV: begin op = FPU_HALF_DIV; uses_rm = 1'b1; end
                        F5_SQRT: begin
                            op      = FPU_HALF_SQRT;
                            uses_rm = 1'b1;
                            illegal = (f.rs2 != 5'd0);
                        end
                        F5_MINMAX: begin
                            op      = FPU_HALF_MINMAX;
                            illegal = (f.rm > RM_RTZ);
                        end
                        F5_SGNJ: begin
                            op      = FPU_HALF_SGNJ;
                            illegal = (f.rm > 3'(FPU_SGNJX));
                        end
                        F5_COMP: begin
                            op      = FPU_HALF_COMP;
                            illegal = (f.rm > 3'b010);
                        end
                        F5_CLASS: begin
                            op      = FPU_HALF_CLASS;
                            illegal = (f.rs2 != 5'd0) || (f.rm != 3'b001);
                        end
                        default: illegal = 1'b1;
                    endcase
                end
            end
`ifdef FPU_FUSED_EN
            OPC_FMADD:  begin op = FPU_HALF_MADD;  uses_rm = 1'b1; illegal = !is_half; end
            OPC_FMSUB:  begin op = FPU_HALF_MSUB;  uses_rm = 1'b1; illegal = !is_half; end
            OPC_FNMADD: begin op = FPU_HALF_NMADD; uses_rm = 1'b1; illegal = !is_half; end
            OPC_FNMSUB: begin op = FPU_HALF_NMSUB; uses_rm = 1'b1; illegal = !is_half; end
`endif
            default: illegal = 1'b1;
        endcase

        // Only arithmetic ops carry a rounding mode; the others keep rm as a sub-op select
        if (uses_rm && rm_is_illegal(rm_res)) begin
            illegal = 1'b1;
        end

        dec.a  = op_a;
        dec.b  = op_b;
`ifdef FPU_FUSED_EN
        dec.c  = op_c;
`else
        dec.c  = '0;
`endif
        dec.rd = f.rd;
        dec.illegal = illegal;
        if (illegal) begin
            dec.op = FPU_HALF_ADD;
            dec.rm = RM_RNE;
        end else begin
            dec.op = op;
            dec.rm = uses_rm ? rm_res : f.rm;
        end
    end

`ifdef FPU_FUSED_EN
    logic unused_fields;
    assign unused_fields = ^f.rs1;
`else
    logic unused_fields;
    assign unused_fields = ^{f.rs1, op_c};
`endif

endmodule

// File: rtl/fpu_decode_stage.sv
// -----------------------------------------------------------------------------
// fpu_decode_stage
// Issue stage of the half-precision FPU: decodes an incoming instruction and
// buffers the decoded record in a 2-entry FIFO towards the execute datapath.
// Also owns the dynamic rounding-mode register frm.
// Ports:
//   CLK, RST (sync, active-high), flush        control
//   in_valid/in_ready, insn, rs1/rs2/rs3_val   upstream handshake + operands
//   frm_we, frm_wdata, frm                      dynamic rounding mode
//   out_valid/out_ready, out_op, out_rm,
//   out_a/b/c, out_rd, out_illegal             FIFO head towards execute
// Parameter DEPTH: FIFO entries, only 2 supported.
// Macro: FPU_FUSED_EN enables fused ops and the rs3 operand storage.
// -----------------------------------------------------------------------------
module fpu_decode_stage
    import fpu_decode_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] insn,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] rs3_val,
    input  logic        frm_we,
    input  logic [2:0]  frm_wdata,
    output logic [2:0]  frm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [2:0]  out_rm,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_c,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    logic [1:0] count_q;
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [2:0] frm_q;

    fpu_decoded_t dec_p0;
    logic         push;
    logic         pop;

    fpu_operation_t    fifo_op_p1  [DEPTH];
    logic [2:0]        fifo_rm_p1  [DEPTH];
    logic [DATA_W-1:0] fifo_a_p1   [DEPTH];
    logic [DATA_W-1:0] fifo_b_p1   [DEPTH];
    logic [4:0]        fifo_rd_p1  [DEPTH];
    logic              fifo_ill_p1 [DEPTH];
`ifdef FPU_FUSED_EN
    logic [DATA_W-1:0] fifo_c_p1   [DEPTH];
`endif

    // ---- p0: combinational decode at acceptance ----
    fpu_insn_decoder u_decoder (
        .insn (insn),
        .frm  (frm_q),
        .op_a (rs1_val[DATA_W-1:0]),
        .op_b (rs2_val[DATA_W-1:0]),
        .op_c (rs3_val[DATA_W-1:0]),
        .dec  (dec_p0)
    );

    // in_ready depends on registered count only, never on out_ready
    assign in_ready  = (count_q < 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    // An input presented during flush is dropped even when in_ready is high
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // frm survives flush; a same-cycle DYN decode sees the old value
    always_ff @(posedge CLK) begin
        if (RST) begin
            frm_q <= RM_RNE;
        end else if (frm_we) begin
            frm_q <= frm_wdata;
        end
    end

    // ---- p1: FIFO storage (cleared on reset so the head reads 0) ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op_p1[i]  <= FPU_HALF_ADD;
                fifo_rm_p1[i]  <= '0;
                fifo_a_p1[i]   <= '0;
                fifo_b_p1[i]   <= '0;
                fifo_rd_p1[i]  <= '0;
                fifo_ill_p1[i] <= 1'b0;
`ifdef FPU_FUSED_EN
                fifo_c_p1[i]   <= '0;
`endif
            end
        end else if (push) begin
            fifo_op_p1[wr_ptr_q]  <= dec_p0.op;
            fifo_rm_p1[wr_ptr_q]  <= dec_p0.rm;
            fifo_a_p1[wr_ptr_q]   <= dec_p0.a;
            fifo_b_p1[wr_ptr_q]   <= dec_p0.b;
            fifo_rd_p1[wr_ptr_q]  <= dec_p0.rd;
            fifo_ill_p1[wr_ptr_q] <= dec_p0.illegal;
`ifdef FPU_FUSED_EN
            fifo_c_p1[wr_ptr_q]   <= dec_p0.c;
`endif
        end
    end

    assign frm         = frm_q;
    assign out_op      = fifo_op_p1[rd_ptr_q];
    assign out_rm      = fifo_rm_p1[rd_ptr_q];
    assign out_a       = fifo_a_p1[rd_ptr_q];
    assign out_b       = fifo_b_p1[rd_ptr_q];
    assign out_rd      = fifo_rd_p1[rd_ptr_q];
    assign out_illegal = fifo_ill_p1[rd_ptr_q];
`ifdef FPU_FUSED_EN
    assign out_c       = fifo_c_p1[rd_ptr_q];
`else
    assign out_c       = '0;
`endif

    // Upper operand halves and the unused decoded c field are intentionally ignored
`ifdef FPU_FUSED_EN
    logic unused_bits;
    assign unused_bits = ^{rs1_val[31:16], rs2_val[31:16], rs3_val[31:16]};
`else
    logic unused_bits;
    assign unused_bits = ^{rs1_val[31:16], rs2_val[31:16], rs3_val[31:16], dec_p0.c};
`endif

endmodule
